// File: rtl/eth_idma_pkg.sv
// Shared types for the Ethernet iDMA request path: default backend payloads and
// the channel-index width helper used to size grant and tracker entries.
package eth_idma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [15:0] length;
    } idma_req_t;

    typedef struct packed {
        logic error;
    } idma_rsp_t;

    // A single-channel build still needs a one-bit index.
    function automatic int chan_idx_w(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/eth_idma_sync_fifo.sv
// Synchronous FIFO with registered storage; head entry is visible the cycle
// after it is written. Push while full is taken only if a pop frees the slot.
module eth_idma_sync_fifo #(
    parameter type T     = logic,
    parameter int  Depth = 4,
    localparam int AddrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int UsageW = $clog2(Depth) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  T                  data_i,
    input  logic              pop_i,
    output T                  data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);

    T                  mem [Depth];
    logic [AddrW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [UsageW-1:0] usage_reg;
    logic              do_push, do_pop;

    assign full_o  = (usage_reg == UsageW'(Depth));
    assign empty_o = (usage_reg == '0);
    assign usage_o = usage_reg;
    assign data_o  = mem[rd_ptr_reg];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] ptr);
        return (ptr == AddrW'(Depth - 1)) ? '0 : ptr + AddrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            usage_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (do_push && !do_pop)      usage_reg <= usage_reg + UsageW'(1);
            else if (do_pop && !do_push) usage_reg <= usage_reg - UsageW'(1);
        end
    end

endmodule

// File: rtl/eth_idma_req_queue.sv
// Per-channel descriptor queues with round-robin issue to one iDMA backend;
// in-order responses are routed back to the issuing channel via a tracker FIFO.
module eth_idma_req_queue #(
    parameter int  NumChannels = 2,
    parameter int  QueueDepth  = 4,
    parameter int  MaxInFlight = 4,
    parameter int  CntWidth    = 16,
    parameter type idma_req_t  = eth_idma_pkg::idma_req_t,
    parameter type idma_rsp_t  = eth_idma_pkg::idma_rsp_t
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  idma_req_t [NumChannels-1:0]          push_req_i,
    input  logic      [NumChannels-1:0]          push_valid_i,
    output logic      [NumChannels-1:0]          push_ready_o,
    output idma_req_t                            idma_req_o,
    output logic                                 req_valid_o,
    input  logic                                 req_ready_i,
    input  idma_rsp_t                            idma_rsp_i,
    input  logic                                 rsp_valid_i,
    output logic                                 rsp_ready_o,
    input  logic      [NumChannels-1:0]          clear_i,
    output logic      [NumChannels-1:0][CntWidth-1:0] done_cnt_o,
    output logic      [NumChannels-1:0]          error_o,
    output logic      [NumChannels-1:0]          irq_o,
    output logic                                 busy_o
);

    localparam int ChW     = eth_idma_pkg::chan_idx_w(NumChannels);
    localparam int QUsageW = $clog2(QueueDepth) + 1;
    localparam int TUsageW = $clog2(MaxInFlight) + 1;

    idma_req_t              q_data  [NumChannels];
    logic [QUsageW-1:0]     q_usage [NumChannels];
    logic [NumChannels-1:0] q_full, q_empty, q_push, q_pop;

    logic [ChW-1:0]     trk_ch;
    logic               trk_full, trk_empty;
    logic [TUsageW-1:0] trk_usage;

    logic [ChW-1:0] rr_ptr_reg, rr_ch, grant_ch, locked_ch_reg;
    logic           locked_reg, rr_found;
    logic           req_hs, rsp_hs;
    logic           busy_reg, busy_next;

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_queue
        assign q_push[gi] = push_valid_i[gi] && !q_full[gi];
        assign q_pop[gi]  = req_hs && (grant_ch == ChW'(gi));

        eth_idma_sync_fifo #(
            .T     (idma_req_t),
            .Depth (QueueDepth)
        ) u_queue (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (q_push[gi]),
            .data_i  (push_req_i[gi]),
            .pop_i   (q_pop[gi]),
            .data_o  (q_data[gi]),
            .full_o  (q_full[gi]),
            .empty_o (q_empty[gi]),
            .usage_o (q_usage[gi])
        );
    end

    assign push_ready_o = ~q_full;

    // First non-empty channel at or after the priority pointer.
    always_comb begin
        int cand;
        cand     = 0;
        rr_ch    = rr_ptr_reg;
        rr_found = 1'b0;
        for (int i = 0; i < NumChannels; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= NumChannels) cand = cand - NumChannels;
            if (!rr_found && !q_empty[ChW'(cand)]) begin
                rr_found = 1'b1;
                rr_ch    = ChW'(cand);
            end
        end
    end

    // A stalled request keeps its channel so later pushes cannot re-arbitrate.
    assign grant_ch    = locked_reg ? locked_ch_reg : rr_ch;
    assign req_valid_o = locked_reg || (rr_found && !trk_full);
    assign idma_req_o  = q_data[grant_ch];
    assign req_hs      = req_valid_o && req_ready_i;

    assign rsp_ready_o = !trk_empty;
    assign rsp_hs      = rsp_valid_i && rsp_ready_o;

    eth_idma_sync_fifo #(
        .T     (logic [ChW-1:0]),
        .Depth (MaxInFlight)
    ) u_tracker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_hs),
        .data_i  (grant_ch),
        .pop_i   (rsp_hs),
        .data_o  (trk_ch),
        .full_o  (trk_full),
        .empty_o (trk_empty),
        .usage_o (trk_usage)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_reg    <= '0;
            locked_reg    <= 1'b0;
            locked_ch_reg <= '0;
        end else if (req_hs) begin
            rr_ptr_reg <= (grant_ch == ChW'(NumChannels - 1)) ? '0 : grant_ch + ChW'(1);
            locked_reg <= 1'b0;
        end else if (req_valid_o) begin
            locked_reg    <= 1'b1;
            locked_ch_reg <= grant_ch;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        logic                complete;
        logic [CntWidth-1:0] cnt_reg;
        logic                err_reg, irq_reg;

        assign complete       = rsp_hs && (trk_ch == ChW'(gi));
        assign done_cnt_o[gi] = cnt_reg;
        assign error_o[gi]    = err_reg;
        assign irq_o[gi]      = irq_reg;

        // A completion coinciding with clear counts as the first event after it.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
                err_reg <= 1'b0;
                irq_reg <= 1'b0;
            end else begin
                irq_reg <= complete;
                if (complete) begin
                    if (clear_i[gi]) begin
                        cnt_reg <= CntWidth'(1);
                        err_reg <= idma_rsp_i.error;
                    end else begin
                        if (cnt_reg != '1) cnt_reg <= cnt_reg + CntWidth'(1);
                        err_reg <= err_reg | idma_rsp_i.error;
                    end
                end else if (clear_i[gi]) begin
                    cnt_reg <= '0;
                    err_reg <= 1'b0;
                end
            end
        end
    end

    // Occupancy after this edge is non-zero iff usage + push differs from pop.
    always_comb begin
        busy_next = (trk_usage + TUsageW'(req_hs)) != TUsageW'(rsp_hs);
        for (int c = 0; c < NumChannels; c++) begin
            if ((q_usage[c] + QUsageW'(q_push[c])) != QUsageW'(q_pop[c])) busy_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) busy_reg <= 1'b0;
        else       busy_reg <= busy_next;
    end

    assign busy_o = busy_reg;

endmodule

// File: tb/tb_eth_idma_req_queue.sv
// Directed bench for eth_idma_req_queue with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_eth_idma_req_queue;
    import eth_idma_pkg::*;

    localparam int NCH  = 2;
    localparam int QD   = 4;
    localparam int MIF  = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic                          clk = 1'b0;
    logic                          rst_i;
    idma_req_t [NCH-1:0]           push_req;
    logic      [NCH-1:0]           push_valid, push_ready, clear, error, irq;
    idma_req_t                     idma_req;
    logic                          req_valid, req_ready;
    idma_rsp_t                     idma_rsp;
    logic                          rsp_valid, rsp_ready;
    logic      [NCH-1:0][CW-1:0]   done_cnt;
    logic                          busy;

    always #5 clk = ~clk;

    eth_idma_req_queue #(
        .NumChannels (NCH),
        .QueueDepth  (QD),
        .MaxInFlight (MIF),
        .CntWidth    (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .push_req_i   (push_req),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .idma_req_o   (idma_req),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .idma_rsp_i   (idma_rsp),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_o  (rsp_ready),
        .clear_i      (clear),
        .done_cnt_o   (done_cnt),
        .error_o      (error),
        .irq_o        (irq),
        .busy_o       (busy)
    );

    // Reference model: plain queues of descriptors and of issuing channels.
    idma_req_t mq [NCH][$];
    int        mt [$];
    int        m_ptr, m_lch;
    bit        m_locked, m_busy;
    int        m_cnt [NCH];
    bit        m_err [NCH];
    bit        m_irq [NCH];

    int        total = 0;
    int        bad   = 0;
    bit        chk_en = 1'b0;
    int        cmp_g;
    idma_req_t exp_req;

    function automatic idma_req_t mk(input int ch, input int seq, input int len);
        idma_req_t r;
        r.src_addr = 32'h1000_0000 + (ch << 16) + seq;
        r.dst_addr = 32'h8000_0000 + (ch << 16) + seq;
        r.length   = 16'(len);
        return r;
    endfunction

    function automatic int m_rr();
        for (int i = 0; i < NCH; i++) begin
            if (mq[(m_ptr + i) % NCH].size() > 0) return (m_ptr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic bit m_valid();
        return m_locked || (m_rr() >= 0 && mt.size() < MIF);
    endfunction

    function automatic int m_grant();
        return m_locked ? m_lch : m_rr();
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_cnt[c] = 0;
            m_err[c] = 1'b0;
            m_irq[c] = 1'b0;
        end
        mt.delete();
        m_ptr    = 0;
        m_lch    = 0;
        m_locked = 1'b0;
        m_busy   = 1'b0;
    endtask

    task automatic model_update();
        bit v, hs_req, hs_rsp;
        int g, rc;
        bit acc [NCH];
        if (rst_i) begin
            model_reset();
            return;
        end
        v      = m_valid();
        g      = m_grant();
        hs_req = v && req_ready;
        hs_rsp = rsp_valid && (mt.size() > 0);
        rc     = hs_rsp ? mt[0] : -1;
        for (int c = 0; c < NCH; c++) acc[c] = push_valid[c] && (mq[c].size() < QD);
        if (hs_rsp) begin
            void'(mt.pop_front());
            $display("rsp ch=%0d err=%0d", rc, idma_rsp.error);
        end
        for (int c = 0; c < NCH; c++) begin
            m_irq[c] = (c == rc);
            if (c == rc) begin
                if (clear[c]) begin
                    m_cnt[c] = 1;
                    m_err[c] = idma_rsp.error;
                end else begin
                    if (m_cnt[c] < CMAX) m_cnt[c]++;
                    m_err[c] = m_err[c] | idma_rsp.error;
                end
            end else if (clear[c]) begin
                m_cnt[c] = 0;
                m_err[c] = 1'b0;
            end
        end
        if (hs_req) begin
            $display("req ch=%0d src=%h len=%0d", g, mq[g][0].src_addr, mq[g][0].length);
            void'(mq[g].pop_front());
            mt.push_back(g);
            m_ptr    = (g + 1) % NCH;
            m_locked = 1'b0;
        end else if (v) begin
            m_locked = 1'b1;
            m_lch    = g;
        end
        for (int c = 0; c < NCH; c++) if (acc[c]) mq[c].push_back(push_req[c]);
        m_busy = mt.size() > 0;
        for (int c = 0; c < NCH; c++) if (mq[c].size() > 0) m_busy = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("push_ready[%0d]", c), push_ready[c], (mq[c].size() < QD));
                chk($sformatf("done_cnt[%0d]", c), done_cnt[c], m_cnt[c]);
                chk($sformatf("error[%0d]", c), error[c], m_err[c]);
                chk($sformatf("irq[%0d]", c), irq[c], m_irq[c]);
            end
            chk("req_valid", req_valid, m_valid());
            chk("rsp_ready", rsp_ready, (mt.size() > 0));
            chk("busy", busy, m_busy);
            if (m_valid()) begin
                cmp_g = m_grant();
                chk("idma_req", idma_req, mq[cmp_g][0]);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        push_valid = '0;
        push_req   = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        idma_rsp   = '0;
        clear      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("rst_push_ready", push_ready, 2'b11);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Single descriptor, one-cycle latency to req_valid, clean completion.
        push_req[0] = mk(0, 0, 64);
        push_valid  = 2'b01;
        req_ready   = 1'b1;
        cyc();
        push_valid = '0;
        chk("t1_req_valid", req_valid, 1'b1);
        chk("t1_len", idma_req.length, 64);
        cyc();
        chk("t1_rsp_ready", rsp_ready, 1'b1);
        rsp_valid      = 1'b1;
        idma_rsp.error = 1'b0;
        cyc();
        rsp_valid = 1'b0;
        chk("t1_done0", done_cnt[0], 1);
        chk("t1_irq0", irq[0], 1'b1);
        chk("t1_busy_fall", busy, 1'b0);
        cyc();
        chk("t1_irq0_pulse", irq[0], 1'b0);

        // Fill both queues; a fifth push is refused while full.
        req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_req[0] = mk(0, k + 1, 128);
            push_req[1] = mk(1, k + 1, 256);
            push_valid  = 2'b11;
            cyc();
            if (k == 3) chk("t2_full", push_ready, 2'b00);
        end
        push_valid = '0;
        exp_req = mk(1, 1, 256);
        chk("t2_first_grant", idma_req, exp_req);
        req_ready = 1'b1;
        cyc(4);
        chk("t2_tracker_stall", req_valid, 1'b0);
        cyc(2);
        chk("t2_still_stalled", req_valid, 1'b0);
        rsp_valid = 1'b1;
        cyc(12);
        rsp_valid = 1'b0;
        cyc(2);
        chk("t2_sat0", done_cnt[0], 3);
        chk("t2_sat1", done_cnt[1], 3);
        chk("t2_idle", busy, 1'b0);

        // Stalled grant stays on ch0 although ch1 gains priority-winning data.
        clear = 2'b11;
        cyc();
        clear = '0;
        chk("t3_cleared", done_cnt, '0);
        req_ready   = 1'b0;
        push_req[0] = mk(0, 9, 512);
        push_valid  = 2'b01;
        cyc();
        push_req[1] = mk(1, 9, 1024);
        push_valid  = 2'b10;
        cyc();
        push_valid = '0;
        cyc(3);
        exp_req = mk(0, 9, 512);
        chk("t3_frozen", idma_req, exp_req);
        req_ready = 1'b1;
        cyc();
        exp_req = mk(1, 9, 1024);
        chk("t3_next_grant", idma_req, exp_req);
        cyc();
        req_ready      = 1'b0;
        rsp_valid      = 1'b1;
        idma_rsp.error = 1'b0;
        cyc();
        idma_rsp.error = 1'b1;
        cyc();
        rsp_valid      = 1'b0;
        idma_rsp.error = 1'b0;
        chk("t3_err1", error[1], 1'b1);
        chk("t3_err0", error[0], 1'b0);
        cyc(2);
        chk("t3_err1_sticky", error[1], 1'b1);
        chk("t3_done1", done_cnt[1], 1);

        // Clear coinciding with a ch1 completion.
        push_req[1] = mk(1, 10, 64);
        push_valid  = 2'b10;
        req_ready   = 1'b1;
        cyc();
        push_valid = '0;
        cyc();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        clear     = 2'b10;
        cyc();
        rsp_valid = 1'b0;
        clear     = '0;
        chk("t3_clr_done1", done_cnt[1], 1);
        chk("t3_clr_err1", error[1], 1'b0);
        chk("t3_clr_irq1", irq[1], 1'b1);

        // Reset with three requests in flight; late responses are ignored.
        push_req[0] = mk(0, 11, 32);
        push_req[1] = mk(1, 11, 32);
        push_valid  = 2'b11;
        cyc();
        push_req[0] = mk(0, 12, 32);
        push_valid  = 2'b01;
        cyc();
        push_valid = '0;
        req_ready  = 1'b1;
        cyc(3);
        req_ready = 1'b0;
        chk("t4_inflight", rsp_ready, 1'b1);
        chk("t4_busy", busy, 1'b1);
        #1 rst_i = 1'b1;
        model_reset();
        cyc();
        chk("t4_rst_req_valid", req_valid, 1'b0);
        chk("t4_rst_rsp_ready", rsp_ready, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_push_ready", push_ready, 2'b11);
        chk("t4_rst_done", done_cnt, '0);
        chk("t4_rst_error", error, '0);
        rst_i     = 1'b0;
        rsp_valid = 1'b1;
        cyc(3);
        chk("t4_late_rsp_ready", rsp_ready, 1'b0);
        chk("t4_late_done", done_cnt, '0);
        chk("t4_late_irq", irq, '0);
        rsp_valid = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
